sync_debounce_bank: RTL and testbench

Parametrised multi-channel input conditioner: each of WIDTH asynchronous inputs passes through a configurable-depth synchronizer chain, then a per-channel debounce filter, producing a clean registered level plus optional one-cycle rise/fall pulses. It sits between the chip's external pins (buttons, interrupt and handshake lines) and the control logic, replacing per-signal two-flop synchronizers instantiated individually.

---
 rtl/sync_debounce_bank_if.sv | 12 +
 rtl/sync_debounce_bank.sv | 91 +++++++++
 tb/tb_sync_debounce_bank.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/sync_debounce_bank_if.sv
// rtl/sync_debounce_bank_if.sv - pin-side and conditioned-level bundle for sync_debounce_bank
interface sync_debounce_bank_if #(
    parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_async;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  modport master (output in_async, input level, input rise, input fall);
  modport slave  (input in_async, output level, output rise, output fall);
endinterface

// File: rtl/sync_debounce_bank.sv
// rtl/sync_debounce_bank.sv - per-channel synchronizer + debounce filter bank
// Optional rise/fall pulse flops enabled by defining SYNC_DEBOUNCE_EDGE_EN.
module sync_debounce_bank #(
    parameter int               WIDTH     = 8,
    parameter int               STAGES    = 2,
    parameter int               DB_CYCLES = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                  clk,
    input logic                  rst,
    sync_debounce_bank_if.slave  bus
);
  localparam int CW = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_debounce_bank: STAGES must be 2..4");
  end
  if (DB_CYCLES < 1) begin : g_bad_db
    $error("sync_debounce_bank: DB_CYCLES must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sync_debounce_bank: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] w_level;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [STAGES-1:0] r_sync;
    logic              r_q;
    logic [CW-1:0]     r_cnt;
    logic              w_synced;
    logic              w_accept;

    assign w_synced = r_sync[STAGES-1];
    assign w_accept = (w_synced != r_q) && (r_cnt == CNT_MAX);

    // Plain shift chain: nothing may sit between the metastability flops.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_sync <= {STAGES{RESET_VAL[i]}};
      end else begin
        r_sync <= {r_sync[STAGES-2:0], bus.in_async[i]};
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_q   <= RESET_VAL[i];
        r_cnt <= '0;
      end else if (w_synced == r_q) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_q   <= w_synced;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_level[i] = r_q;

`ifdef SYNC_DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Pulses share the acceptance edge, so they line up with the level change.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= w_accept && w_synced;
        r_fall <= w_accept && !w_synced;
      end
    end

    assign w_rise[i] = r_rise;
    assign w_fall[i] = r_fall;
`else
    assign w_rise[i] = 1'b0;
    assign w_fall[i] = 1'b0;
`endif
  end

  assign bus.level = w_level;
  assign bus.rise  = w_rise;
  assign bus.fall  = w_fall;
endmodule

// File: tb/tb_sync_debounce_bank.sv
// tb/tb_sync_debounce_bank.sv - vectors, corner sequences and random run against a window model
module tb_sync_debounce_bank;
  localparam int W  = 8;
  localparam int ST = 2;
  localparam int DB = 4;
  localparam logic [W-1:0] RV = '0;
`ifdef SYNC_DEBOUNCE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_debounce_bank_if #(.WIDTH(W)) bus ();
  sync_debounce_bank_if #(.WIDTH(1)) bus1 ();

  sync_debounce_bank #(.WIDTH(W), .STAGES(ST), .DB_CYCLES(DB), .RESET_VAL(RV)) u_dut (
      .clk(clk), .rst(rst), .bus(bus.slave));
  sync_debounce_bank #(.WIDTH(1), .STAGES(3), .DB_CYCLES(1), .RESET_VAL(1'b0)) u_dut1 (
      .clk(clk), .rst(rst), .bus(bus1.slave));

  int total = 0;
  int bad = 0;

  // Reference: a level flips once the last DB pre-edge synced samples all disagree with it.
  logic [W-1:0] in_hist[$];
  logic [W-1:0] syn_hist[$];
  logic [W-1:0] m_level, m_rise, m_fall;
  logic         h1[$];
  logic         m1_level, m1_rise, m1_fall;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic [W-1:0] a, input logic r);
    logic [W-1:0] syn;
    logic         all_diff, prev1;
    m_rise = '0;
    m_fall = '0;
    m1_rise = 1'b0;
    m1_fall = 1'b0;
    if (r) begin
      in_hist = {};
      syn_hist = {};
      repeat (ST) in_hist.push_front(RV);
      repeat (DB) syn_hist.push_front(RV);
      m_level = RV;
      h1 = {};
      repeat (3) h1.push_front(1'b0);
      m1_level = 1'b0;
    end else begin
      syn = in_hist[ST-1];
      in_hist.push_front(a);
      void'(in_hist.pop_back());
      syn_hist.push_front(syn);
      void'(syn_hist.pop_back());
      for (int c = 0; c < W; c++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++)
          if (syn_hist[j][c] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_rise[c] = 1'b1;
          else m_fall[c] = 1'b1;
        end
      end
      prev1 = m1_level;
      m1_level = h1[2];
      h1.push_front(a[0]);
      void'(h1.pop_back());
      m1_rise = !prev1 && m1_level;
      m1_fall = prev1 && !m1_level;
    end
  endtask

  task automatic step(input logic [W-1:0] a, input logic r);
    @(negedge clk);
    bus.in_async = a;
    bus1.in_async = a[0];
    rst = r;
    @(posedge clk);
    #1;
    model_edge(a, r);
    check("level", bus.level, m_level);
    check("rise", bus.rise, EDGE ? m_rise : '0);
    check("fall", bus.fall, EDGE ? m_fall : '0);
    check("both_hi", bus.rise & bus.fall, '0);
    check("p1_level", {7'd0, bus1.level}, {7'd0, m1_level});
    check("p1_rise", {7'd0, bus1.rise}, EDGE ? {7'd0, m1_rise} : '0);
    check("p1_fall", {7'd0, bus1.fall}, EDGE ? {7'd0, m1_fall} : '0);
  endtask

  typedef struct {
    logic [W-1:0] din;
    logic         r;
    logic [W-1:0] lvl;
    logic [W-1:0] rs;
    logic [W-1:0] fl;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic [W-1:0] d, logic r, logic [W-1:0] l,
                              logic [W-1:0] rs, logic [W-1:0] fl);
    vec_t v;
    v.din = d; v.r = r; v.lvl = l; v.rs = rs; v.fl = fl;
    return v;
  endfunction

  initial begin
    logic [W-1:0] cur;
    bus.in_async = 8'hFF;
    bus1.in_async = 1'b1;

    // Reset with all pins high, release, then a single-channel fall and rise on ch3.
    repeat (2) tbl.push_back(mk(8'hFF, 1'b1, 8'h00, 8'h00, 8'h00));
    repeat (5) tbl.push_back(mk(8'hFF, 1'b0, 8'h00, 8'h00, 8'h00));
    tbl.push_back(mk(8'hFF, 1'b0, 8'hFF, 8'hFF, 8'h00));
    tbl.push_back(mk(8'hFF, 1'b0, 8'hFF, 8'h00, 8'h00));
    repeat (5) tbl.push_back(mk(8'hF7, 1'b0, 8'hFF, 8'h00, 8'h00));
    tbl.push_back(mk(8'hF7, 1'b0, 8'hF7, 8'h00, 8'h08));
    tbl.push_back(mk(8'hF7, 1'b0, 8'hF7, 8'h00, 8'h00));
    repeat (5) tbl.push_back(mk(8'hFF, 1'b0, 8'hF7, 8'h00, 8'h00));
    tbl.push_back(mk(8'hFF, 1'b0, 8'hFF, 8'h08, 8'h00));
    tbl.push_back(mk(8'hFF, 1'b0, 8'hFF, 8'h00, 8'h00));

    foreach (tbl[i]) begin
      step(tbl[i].din, tbl[i].r);
      check($sformatf("vec%0d_level", i), bus.level, tbl[i].lvl);
      check($sformatf("vec%0d_rise", i), bus.rise, EDGE ? tbl[i].rs : '0);
      check($sformatf("vec%0d_fall", i), bus.fall, EDGE ? tbl[i].fl : '0);
    end

    // Asynchronous reset must clear outputs without waiting for a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_level", bus.level, RV);
    check("async_rst_rise", bus.rise, '0);
    step(8'h00, 1'b1);
    repeat (8) step(8'h00, 1'b0);

    // Glitch shorter than DB on ch0 is dropped; a DB-long pulse is accepted.
    repeat (3) step(8'h01, 1'b0);
    repeat (8) step(8'h00, 1'b0);
    check("glitch3_level", bus.level, 8'h00);
    repeat (4) step(8'h01, 1'b0);
    repeat (2) step(8'h00, 1'b0);
    check("pulse4_rise_level", bus.level, 8'h01);
    check("pulse4_rise_pulse", bus.rise, EDGE ? 8'h01 : 8'h00);
    repeat (3) step(8'h00, 1'b0);
    check("pulse4_hold", bus.level, 8'h01);
    step(8'h00, 1'b0);
    check("pulse4_fall_level", bus.level, 8'h00);
    check("pulse4_fall_pulse", bus.fall, EDGE ? 8'h01 : 8'h00);
    repeat (4) step(8'h00, 1'b0);

    // Bouncing ch5 settles high: one accepted edge, DB cycles after synced settles.
    step(8'h20, 1'b0); step(8'h00, 1'b0); step(8'h20, 1'b0); step(8'h00, 1'b0);
    repeat (5) step(8'h20, 1'b0);
    check("bounce_wait", bus.level, 8'h00);
    step(8'h20, 1'b0);
    check("bounce_level", bus.level, 8'h20);
    check("bounce_rise", bus.rise, EDGE ? 8'h20 : 8'h00);
    repeat (6) step(8'h00, 1'b0);

    // Reset while ch2 is mid-count; counting restarts from zero afterwards.
    repeat (4) step(8'h04, 1'b0);
    step(8'h04, 1'b1);
    check("midcnt_rst_level", bus.level, RV);
    repeat (5) step(8'h04, 1'b0);
    check("midcnt_restart_wait", bus.level, 8'h00);
    step(8'h04, 1'b0);
    check("midcnt_restart_level", bus.level, 8'h04);

    // Random run: sparse per-bit toggles so both glitches and accepted edges occur.
    cur = 8'h00;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      if ($urandom_range(0, 199) == 0) cur = cur ^ 8'h5A;
      step(cur, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
